// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - host-side stream initiator for the AES encrypt/decrypt core
//
// Accepts 128-bit blocks on a valid/ready input stream, loads them into the AES
// core with a one-cycle strobe, waits for the core's done pulse and queues the
// result in a small FIFO that drains on a valid/ready output stream. Only one
// block is ever in flight, and FIFO space is reserved at accept time, so a done
// pulse always has somewhere to land.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        upstream handshake; in_mode/in_key/in_text payload
//   core_ld                  one-cycle load strobe to the core
//   core_mode/key/text       registered operands, held until the next accept
//   core_text_out, core_done core result and its one-cycle done pulse
//   out_valid/out_ready      downstream handshake; out_text/out_mode head entry
//   err                      sticky: timeout or done pulse with nothing in flight
//   blk_cnt, to_cnt          push / timeout counters (AES_STREAM_CTRL_PERFCNT_EN only)
//
// Optional feature macro: AES_STREAM_CTRL_PERFCNT_EN
`timescale 1ns/1ps

module aes_stream_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_key,
  input  logic [127:0] in_text,
  output logic         core_ld,
  output logic         core_mode,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  input  logic [127:0] core_text_out,
  input  logic         core_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         out_mode,
`ifdef AES_STREAM_CTRL_PERFCNT_EN
  output logic [31:0]  blk_cnt,
  output logic [15:0]  to_cnt,
`endif
  output logic         err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;
  logic            run_q;
  logic            core_mode_q;
  logic [127:0]    core_key_q, core_text_q;

  logic [127:0]    mem_text_q [FIFO_DEPTH];
  logic            mem_mode_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic            accept, push, pop, timeout;

  // run_q holds in_ready low while reset is asserted, since IDLE with an empty
  // FIFO would otherwise advertise ready straight out of reset.
  assign in_ready  = run_q && (state_q == IDLE) && (count_q < CW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign core_ld   = (state_q == LOAD);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_text  = mem_text_q[rptr_q];
  assign out_mode  = mem_mode_q[rptr_q];
  assign core_mode = core_mode_q;
  assign core_key  = core_key_q;
  assign core_text = core_text_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    push    = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        timer_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        timer_d = timer_q + 1'b1;
        // done wins over a timeout landing in the same cycle
        if (core_done) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (timer_d == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = err_q | timeout | (core_done && (state_q != BUSY));

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      err_q       <= 1'b0;
      run_q       <= 1'b0;
      core_mode_q <= 1'b0;
      core_key_q  <= '0;
      core_text_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
      if (accept) begin
        core_mode_q <= in_mode;
        core_key_q  <= in_key;
        core_text_q <= in_text;
      end
    end
  end

  // Entries are reset so out_text/out_mode read zero with an empty FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_text_q[i] <= '0;
        mem_mode_q[i] <= 1'b0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_text_q[wptr_q] <= core_text_out;
        mem_mode_q[wptr_q] <= core_mode_q;
        wptr_q             <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

`ifdef AES_STREAM_CTRL_PERFCNT_EN
  logic [31:0] blk_cnt_q;
  logic [15:0] to_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      if (push)    blk_cnt_q <= blk_cnt_q + 1'b1;
      if (timeout) to_cnt_q  <= to_cnt_q + 1'b1;
    end
  end

  assign blk_cnt = blk_cnt_q;
  assign to_cnt  = to_cnt_q;
`endif

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - directed self-checking bench for aes_stream_ctrl
`timescale 1ns/1ps

module tb_aes_stream_ctrl;

  localparam int T = 64;
  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h0f0e0d0c0b0a09080706050403020100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_mode = 1'b0;
  logic [127:0] in_key = '0;
  logic [127:0] in_text = '0;
  logic         core_ld;
  logic         core_mode;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic [127:0] core_text_out = '0;
  logic         core_done;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_text;
  logic         out_mode;
  logic         err;
`ifdef AES_STREAM_CTRL_PERFCNT_EN
  logic [31:0]  blk_cnt;
  logic [15:0]  to_cnt;
`endif

  logic stub_done = 1'b0;
  logic tb_done   = 1'b0;
  logic stub_en   = 1'b0;
  int   stub_lat  = 3;
  int   cyc       = 0;
  int   n_chk     = 0;
  int   n_pass    = 0;

  assign core_done = stub_done | tb_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_stream_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_key(in_key), .in_text(in_text),
    .core_ld(core_ld), .core_mode(core_mode), .core_key(core_key), .core_text(core_text),
    .core_text_out(core_text_out), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text), .out_mode(out_mode),
`ifdef AES_STREAM_CTRL_PERFCNT_EN
    .blk_cnt(blk_cnt), .to_cnt(to_cnt),
`endif
    .err(err)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stand-in for the AES core: the two known FIPS-197 vectors, anything else
  // maps to text ^ key, inverted for decrypt.
  function automatic logic [127:0] model(input logic m, input logic [127:0] k, input logic [127:0] t);
    if (k == K && !m && t == PT) return CT;
    if (k == K &&  m && t == CT) return PT;
    return t ^ k ^ {128{m}};
  endfunction

  always begin
    @(negedge clk);
    if (core_ld && stub_en) begin
      repeat (stub_lat) @(negedge clk);
      core_text_out = model(core_mode, core_key, core_text);
      stub_done = 1'b1;
      @(negedge clk);
      stub_done = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge (LOAD cycle).
  task automatic send(input logic m, input logic [127:0] k, input logic [127:0] t);
    int n = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_key   = k;
    in_text  = t;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", n < 200, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("out_wait", n < 200, 1);
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [127:0] bp_text [5];
  logic         bp_mode [5];

  initial begin
    int popped, n, t0;
    logic acc, drop, seen_ov;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_outs", {in_ready, core_ld, core_mode, out_valid, out_mode, err}, 0);
    check("rst_vecs", {core_key | core_text, out_text}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_rst", in_ready, 1);

    // 1: encrypt
    stub_en  = 1'b1;
    stub_lat = 3;
    send(1'b0, K, PT);
    check("t1_ld", core_ld, 1);
    check("t1_core_text", core_text, PT);
    check("t1_busy_ready", in_ready, 0);
    wait_out();
    check("t1_text", out_text, CT);
    check("t1_mode", out_mode, 0);
    check("t1_err", err, 0);
    pop1();
    check("t1_empty", out_valid, 0);

    // 2: decrypt
    send(1'b1, K, CT);
    wait_out();
    check("t2_text", out_text, PT);
    check("t2_mode", out_mode, 1);
    pop1();

    // 3: backpressure
    stub_lat = 2;
    for (int i = 0; i < 5; i++) begin
      bp_text[i] = {4{32'h11111111 * (i + 1)}};
      bp_mode[i] = i[0];
    end
    for (int i = 0; i < 4; i++) send(bp_mode[i], KB, bp_text[i]);
    repeat (10) @(negedge clk);
    check("t3_full_ready", in_ready, 0);
    check("t3_full_valid", out_valid, 1);
    in_valid = 1'b1;
    in_mode  = bp_mode[4];
    in_key   = KB;
    in_text  = bp_text[4];
    repeat (3) @(negedge clk);
    check("t3_blocked", in_ready, 0);
    out_ready = 1'b1;
    popped = 0; acc = 1'b0; drop = 1'b0; n = 0;
    while ((popped < 5 || !acc) && n < 100) begin
      if (drop) begin in_valid = 1'b0; drop = 1'b0; end
      if (in_valid && in_ready) begin
        check("t3_acc_after_pop", popped != 0, 1);
        acc = 1'b1; drop = 1'b1;
      end
      if (out_valid) begin
        check($sformatf("t3_text%0d", popped), out_text, bp_text[popped] ^ KB ^ {128{bp_mode[popped]}});
        check($sformatf("t3_mode%0d", popped), out_mode, bp_mode[popped]);
        popped++;
      end
      @(negedge clk);
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t3_all", {popped == 5, acc}, 2'b11);
    check("t3_drained", out_valid, 0);
    check("t3_err", err, 0);

    // 5: spurious done in IDLE
    tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    @(negedge clk);
    check("t5_err", err, 1);
    check("t5_no_push", {out_valid, in_ready}, 2'b01);

    // 6: reset mid-BUSY, late done afterwards
    stub_lat = 8;
    send(1'b0, K, PT);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_outs", {in_ready, core_ld, core_mode, out_valid, out_mode, err}, 0);
    check("t6_rst_vecs", {core_key | core_text, out_text}, 0);
    @(negedge clk);
    rst = 1'b1;
    check("t6_err_clr", err, 0);
    seen_ov = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_ov = seen_ov | out_valid;
    end
    check("t6_late_err", err, 1);
    check("t6_no_push", seen_ov, 0);

    // 4: timeout
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    stub_en = 1'b0;
    send(1'b1, K, PT);
    check("t4_ld", core_ld, 1);
    t0 = cyc; n = 0; seen_ov = 1'b0;
    while (!err && n < 200) begin
      @(negedge clk);
      seen_ov = seen_ov | out_valid;
      n++;
    end
    check("t4_err_delay", cyc - t0, T);
    check("t4_no_valid", seen_ov, 0);
    stub_en  = 1'b1;
    stub_lat = 3;
    send(1'b0, K, PT);
    wait_out();
    check("t4_next_text", out_text, CT);
    pop1();
`ifdef AES_STREAM_CTRL_PERFCNT_EN
    check("perf_blk", blk_cnt, 1);
    check("perf_to", to_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
